delay_monitor: RTL and testbench

DELAY_MONITOR -- requirements
Module: delay_monitor

---
 rtl/delay_pkg.sv | 13 +
 rtl/delay_monitor_edge_detect.sv | 22 ++
 rtl/delay_monitor.sv | 98 +++++++++
 tb/tb_delay_monitor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared definitions for the delay monitor: FSM state encoding and default sizing.
package delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_W    = 4;
    localparam int unsigned DEF_MAX_WAIT = 15;

endpackage

// File: rtl/delay_monitor_edge_detect.sv
// Rising-edge detector: registers the input every cycle and flags a 0->1 transition
// seen at the current edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic sense_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sense_q <= 1'b0;
        end else begin
            sense_q <= in;
        end
    end

    assign rise = in & ~sense_q;

endmodule

// File: rtl/delay_monitor.sv
// Measures the number of clock cycles between an accepted start request and the next
// rising edge on sense, giving up after MAX_WAIT cycles and reporting a timeout.
module delay_monitor
    import delay_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sense,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] delay_count,
    output logic [1:0]       state_out
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_e           state_q;
    logic [CNT_W-1:0] elapsed_q;
    logic [CNT_W-1:0] elapsed_d;
    logic [CNT_W-1:0] delay_q;
    logic             timeout_q;
    logic             busy_q;
    logic             done_q;
    logic             rise;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (sense),
        .rise (rise)
    );

    // elapsed_q stays at most MAX_WAIT-1, so the increment never wraps.
    assign elapsed_d = elapsed_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            elapsed_q <= '0;
            delay_q   <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_WAIT;
                        elapsed_q <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A rise on the final allowed cycle takes priority over the timeout.
                    if (rise) begin
                        state_q   <= ST_REPORT;
                        delay_q   <= elapsed_d;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (elapsed_d == MAX_CNT) begin
                        state_q   <= ST_REPORT;
                        delay_q   <= MAX_CNT;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        elapsed_q <= elapsed_d;
                    end
                end
                ST_REPORT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign delay_count = delay_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Directed and randomized bench for delay_monitor; expectations come from scanning the
// driven sense waveform for the first 0->1 transition after start.
module tb_delay_monitor;
    import delay_pkg::*;

    localparam int CNT_W    = DEF_CNT_W;
    localparam int MAX_WAIT = DEF_MAX_WAIT;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sense = 1'b0;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] delay_count;
    logic [1:0]       state_out;

    int checks = 0;
    int errors = 0;

    // sv[k] is the sense level sampled at the k-th edge after the start edge (k=0).
    bit sv [0:MAX_WAIT+1];
    int last_cnt = 0;
    int last_to  = 0;

    delay_monitor #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sense       (sense),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .delay_count (delay_count),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_step(input int rise_at, input bit level_before);
        for (int k = 0; k <= MAX_WAIT + 1; k++)
            sv[k] = (rise_at > 0 && k >= rise_at) ? 1'b1 : level_before;
    endtask

    // One measurement starting from IDLE; restart_at re-asserts start during WAIT.
    task automatic measure(input string name, input int restart_at);
        int rk;
        int end_k;
        int exp_cnt;
        int exp_to;
        rk = 0;
        for (int k = 1; k <= MAX_WAIT; k++)
            if (rk == 0 && sv[k] && !sv[k-1]) rk = k;
        exp_to  = (rk == 0) ? 1 : 0;
        exp_cnt = (rk == 0) ? MAX_WAIT : rk;
        end_k   = exp_cnt;

        start = 1'b1;
        sense = sv[0];
        @(posedge clk); #1;
        start = 1'b0;
        sense = sv[1];
        chk({name, "_accept_state"}, state_out, 32'd1);
        chk({name, "_accept_busy_done"}, {busy, done}, 32'b10);
        for (int k = 1; k <= end_k; k++) begin
            if (k == restart_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            sense = sv[k+1];
            if (k < end_k) begin
                chk({name, "_wait_busy_done"}, {busy, done}, 32'b10);
            end else begin
                chk({name, "_report_busy_done"}, {busy, done}, 32'b01);
                chk({name, "_delay_count"}, delay_count, exp_cnt);
                chk({name, "_timeout"}, timeout, exp_to);
                chk({name, "_report_state"}, state_out, 32'd2);
            end
        end
        @(posedge clk); #1;
        chk({name, "_idle_state_done"}, {state_out, done}, 32'b000);
        chk({name, "_hold_count"}, delay_count, exp_cnt);
        last_cnt = exp_cnt;
        last_to  = exp_to;
        $display("measure %s: rise_edge=%0d delay_count=%0d timeout=%0d (expected %0d/%0d)",
                 name, rk, delay_count, timeout, exp_cnt, exp_to);
    endtask

    initial begin
        #2;
        chk("reset_outputs", {busy, done, timeout, delay_count, state_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy, done, state_out}, 32'd0);

        fill_step(10, 1'b0);
        measure("rise10", 0);
        fill_step(0, 1'b0);
        measure("low_timeout", 0);
        fill_step(0, 1'b1);
        measure("high_timeout", 0);
        fill_step(MAX_WAIT, 1'b0);
        measure("rise_last", 0);
        fill_step(7, 1'b0);
        measure("restart_ignored", 4);
        fill_step(1, 1'b0);
        measure("rise1_a", 0);
        fill_step(1, 1'b0);
        measure("rise1_backtoback", 0);

        // Idle with start low keeps the last result.
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_hold", {state_out, timeout, delay_count}, {last_to, last_cnt[CNT_W-1:0]});
        end

        // Reset during WAIT aborts without a done pulse.
        fill_step(0, 1'b0);
        start = 1'b1;
        sense = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, timeout, delay_count, state_out}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_done", {done, state_out}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        fill_step(6, 1'b0);
        measure("after_reset", 0);

        for (int t = 0; t < 40; t++) begin
            int thr;
            int gap;
            thr = $urandom_range(0, 9);
            for (int k = 0; k <= MAX_WAIT + 1; k++)
                sv[k] = ($urandom_range(0, 9) < thr);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
                chk("rand_gap_hold", {timeout, delay_count}, {last_to, last_cnt[CNT_W-1:0]});
            end
            measure($sformatf("rand%0d", t), $urandom_range(0, MAX_WAIT));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
